// File: rtl/iot_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : iot_event_arbiter
//  Description : Round-robin arbiter and sequencer in front of the active-IoT-
//                device counter. It accepts connect/disconnect events from N
//                requesters, serialises them into single-cycle change/on_off
//                pulses, sequences multi-cycle counter clears, and keeps a
//                shadow count so underflow/overflow events are dropped.
//                Optional macro IOT_ARB_STATS_EN adds forwarded/dropped event
//                counters (fwd_cnt, drop_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module iot_event_arbiter #(
    parameter int N          = 4,
    parameter int CLR_CYCLES = 2,
    parameter int WRAP       = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_valid,
    input  logic [N-1:0] req_on,
    output logic [N-1:0] req_ready,
    input  logic         clr_req,
    output logic         clr_busy,
    output logic         mon_rst,
    output logic         mon_change,
    output logic         mon_on_off,
    output logic [7:0]   active_cnt,
    output logic         drop_err
`ifdef IOT_ARB_STATS_EN
    ,
    output logic [15:0]  fwd_cnt,
    output logic [15:0]  drop_cnt
`endif
);

    localparam int            C_PW       = (N > 1) ? $clog2(N) : 1;
    localparam int            C_CW       = 4;
    localparam logic [C_CW-1:0] C_CLR_LAST = C_CW'(CLR_CYCLES - 1);
    localparam logic          C_WRAP     = (WRAP != 0);
    localparam logic [C_PW:0] C_N        = (C_PW + 1)'(N);
    localparam logic [C_PW-1:0] C_LAST_IDX = C_PW'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [C_PW-1:0]  ptr_q, ptr_d;
    logic [C_CW-1:0]  clr_cnt_q, clr_cnt_d;
    logic             mon_rst_q, mon_rst_d;
    logic             clr_busy_q, clr_busy_d;
    logic             mon_change_q, mon_change_d;
    logic             mon_on_off_q, mon_on_off_d;
    logic             drop_err_q, drop_err_d;
    logic [7:0]       active_cnt_q, active_cnt_d;

    logic             grant_vld;
    logic [C_PW-1:0]  grant_idx;
    logic [C_PW:0]    scan_sum;
    logic [C_PW-1:0]  scan_idx;
    logic             ev_fwd;
    logic             ev_drop;
    logic             clr_enter;

    // Round-robin scan: first valid requester at or after the pointer, wrapping.
    // Grants are suppressed in reset, during a clear, and when a clear is requested.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        if (rst_n && (state_q == ST_IDLE) && !clr_req) begin
            for (int k = 0; k < N; k++) begin
                scan_sum = {1'b0, ptr_q} + (C_PW + 1)'(k);
                if (scan_sum >= C_N) begin
                    scan_sum = scan_sum - C_N;
                end
                scan_idx = scan_sum[C_PW-1:0];
                if (!grant_vld && req_valid[scan_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    assign req_ready = grant_vld ? (N'(1) << grant_idx) : '0;

    // Next-state and registered-output computation for the IDLE/CLEAR sequencer.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        clr_cnt_d    = clr_cnt_q;
        mon_rst_d    = 1'b0;
        clr_busy_d   = 1'b0;
        mon_change_d = 1'b0;
        mon_on_off_d = 1'b0;
        drop_err_d   = 1'b0;
        active_cnt_d = active_cnt_q;
        ev_fwd       = 1'b0;
        ev_drop      = 1'b0;
        clr_enter    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d      = ST_CLEAR;
                    clr_cnt_d    = '0;
                    mon_rst_d    = 1'b1;
                    clr_busy_d   = 1'b1;
                    active_cnt_d = 8'h00;
                    clr_enter    = 1'b1;
                end else if (grant_vld) begin
                    ptr_d = (grant_idx == C_LAST_IDX) ? '0 : grant_idx + C_PW'(1);
                    if (req_on[grant_idx]) begin
                        // Count-up: blocked at 255 unless wrap-around is enabled.
                        if ((active_cnt_q != 8'hFF) || C_WRAP) begin
                            mon_change_d = 1'b1;
                            mon_on_off_d = 1'b1;
                            active_cnt_d = active_cnt_q + 8'd1;
                            ev_fwd       = 1'b1;
                        end else begin
                            drop_err_d = 1'b1;
                            ev_drop    = 1'b1;
                        end
                    end else begin
                        // Count-down: never let the counter underflow.
                        if (active_cnt_q != 8'h00) begin
                            mon_change_d = 1'b1;
                            active_cnt_d = active_cnt_q - 8'd1;
                            ev_fwd       = 1'b1;
                        end else begin
                            drop_err_d = 1'b1;
                            ev_drop    = 1'b1;
                        end
                    end
                end
            end
            ST_CLEAR: begin
                active_cnt_d = 8'h00;
                if (clr_cnt_q == C_CLR_LAST) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d  = clr_cnt_q + C_CW'(1);
                    mon_rst_d  = 1'b1;
                    clr_busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset abandons any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            clr_cnt_q    <= '0;
            mon_rst_q    <= 1'b0;
            clr_busy_q   <= 1'b0;
            mon_change_q <= 1'b0;
            mon_on_off_q <= 1'b0;
            drop_err_q   <= 1'b0;
            active_cnt_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            clr_cnt_q    <= clr_cnt_d;
            mon_rst_q    <= mon_rst_d;
            clr_busy_q   <= clr_busy_d;
            mon_change_q <= mon_change_d;
            mon_on_off_q <= mon_on_off_d;
            drop_err_q   <= drop_err_d;
            active_cnt_q <= active_cnt_d;
        end
    end

    assign mon_rst    = mon_rst_q;
    assign clr_busy   = clr_busy_q;
    assign mon_change = mon_change_q;
    assign mon_on_off = mon_on_off_q;
    assign drop_err   = drop_err_q;
    assign active_cnt = active_cnt_q;

`ifdef IOT_ARB_STATS_EN
    logic [15:0] fwd_cnt_q, fwd_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating event statistics, zeroed whenever a clear starts.
    always_comb begin
        fwd_cnt_d  = fwd_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_enter) begin
            fwd_cnt_d  = 16'h0000;
            drop_cnt_d = 16'h0000;
        end else begin
            if (ev_fwd && (fwd_cnt_q != 16'hFFFF)) begin
                fwd_cnt_d = fwd_cnt_q + 16'd1;
            end
            if (ev_drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_cnt_q  <= 16'h0000;
            drop_cnt_q <= 16'h0000;
        end else begin
            fwd_cnt_q  <= fwd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign fwd_cnt  = fwd_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iot_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iot_event_arbiter
//  Description : Randomised scoreboard bench for iot_event_arbiter. Two
//                instances (no-wrap/2-cycle clear and wrap/3-cycle clear)
//                share stimulus; a reference model per instance predicts the
//                observable outputs of every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iot_event_arbiter;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic [3:0] req_valid = 4'b0000;
    logic [3:0] req_on    = 4'b0000;
    logic       clr_req   = 1'b0;

    logic [3:0] rdy0, rdy1;
    logic       busy0, busy1, mrst0, mrst1, chg0, chg1, onf0, onf1, derr0, derr1;
    logic [7:0] cnt0, cnt1;

    always #5 clk = ~clk;

    iot_event_arbiter #(.N(4), .CLR_CYCLES(2), .WRAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_on(req_on),
        .req_ready(rdy0), .clr_req(clr_req), .clr_busy(busy0), .mon_rst(mrst0),
        .mon_change(chg0), .mon_on_off(onf0), .active_cnt(cnt0), .drop_err(derr0)
    );

    iot_event_arbiter #(.N(4), .CLR_CYCLES(3), .WRAP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_on(req_on),
        .req_ready(rdy1), .clr_req(clr_req), .clr_busy(busy1), .mon_rst(mrst1),
        .mon_change(chg1), .mon_on_off(onf1), .active_cnt(cnt1), .drop_err(derr1)
    );

    // Reference model state: plain integer count, pointer and remaining clear cycles.
    int          m_cnt  [2];
    int          m_ptr  [2];
    int          m_left [2];
    logic [12:0] m_out  [2];   // {mon_rst, clr_busy, mon_change, mon_on_off, drop_err, cnt}
    int          clr_len [2] = '{2, 3};
    int          wrap_en [2] = '{0, 1};

    // Expected {req_ready, outputs} per cycle, sampled mid-cycle.
    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [3:0]  last_rdy = 4'b0000;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          done = 1'b0;

    task automatic model_step(input int i, output logic [16:0] e);
        logic [3:0] rdy;
        int         j;
        logic       o_rst, o_busy, o_chg, o_on, o_derr;
        rdy = 4'b0000;
        j   = -1;
        if (!rst_n) begin
            m_cnt[i]  = 0;
            m_ptr[i]  = 0;
            m_left[i] = 0;
            m_out[i]  = '0;
            e         = '0;
            return;
        end
        if (m_left[i] == 0 && !clr_req) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr[i] + k) % 4;
                if (j < 0 && req_valid[idx]) j = idx;
            end
        end
        if (j >= 0) rdy[j] = 1'b1;
        e = {rdy, m_out[i]};
        o_rst = 0; o_busy = 0; o_chg = 0; o_on = 0; o_derr = 0;
        if (m_left[i] > 0) begin
            m_left[i] = m_left[i] - 1;
            m_cnt[i]  = 0;
            if (m_left[i] > 0) begin o_rst = 1; o_busy = 1; end
        end else if (clr_req) begin
            m_left[i] = clr_len[i];
            m_cnt[i]  = 0;
            o_rst = 1; o_busy = 1;
        end else if (j >= 0) begin
            m_ptr[i] = (j + 1) % 4;
            if (req_on[j]) begin
                if (m_cnt[i] < 255 || wrap_en[i] != 0) begin
                    m_cnt[i] = (m_cnt[i] + 1) % 256;
                    o_chg = 1; o_on = 1;
                end else begin
                    o_derr = 1;
                end
            end else if (m_cnt[i] > 0) begin
                m_cnt[i] = m_cnt[i] - 1;
                o_chg = 1;
            end else begin
                o_derr = 1;
            end
        end
        m_out[i] = {o_rst, o_busy, o_chg, o_on, o_derr, 8'(m_cnt[i])};
    endtask

    // One stimulus cycle: randomise inputs at the falling edge, then record predictions.
    // pv/pon/pclr in percent, prst in per-mille.
    task automatic drive_cycle(input int pv, input int pon, input int pclr, input int prst);
        logic [16:0] e0, e1;
        @(negedge clk);
        cyc = cyc + 1;
        if (!rst_n) rst_n = ($urandom_range(99, 0) < 50);
        else if ($urandom_range(999, 0) < prst) rst_n = 1'b0;
        clr_req = ($urandom_range(99, 0) < pclr);
        for (int r = 0; r < 4; r++) begin
            if (req_valid[r] && !last_rdy[r]) begin
                if ($urandom_range(99, 0) < 3) req_valid[r] = 1'b0;
            end else begin
                req_valid[r] = ($urandom_range(99, 0) < pv);
                if (req_valid[r]) req_on[r] = ($urandom_range(99, 0) < pon);
            end
        end
        #1;
        model_step(0, e0);
        q0.push_back(e0);
        model_step(1, e1);
        q1.push_back(e1);
        last_rdy = e0[16:13];
    endtask

    // Monitor: pops one prediction per instance each cycle and compares.
    initial begin
        logic [16:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            #2;
            if (!done) begin
                act_v = {rdy0, mrst0, busy0, chg0, onf0, derr0, cnt0};
                vectors = vectors + 1;
                if (q0.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL dut0 cycle %0d: output %h with no expected entry", cyc, act_v);
                end else begin
                    exp_v = q0.pop_front();
                    if (act_v !== exp_v) begin
                        miscompares = miscompares + 1;
                        $display("FAIL dut0 cycle %0d: got rdy/rst/busy/chg/on/err/cnt %h, want %h", cyc, act_v, exp_v);
                    end
                end
                act_v = {rdy1, mrst1, busy1, chg1, onf1, derr1, cnt1};
                vectors = vectors + 1;
                if (q1.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL dut1 cycle %0d: output %h with no expected entry", cyc, act_v);
                end else begin
                    exp_v = q1.pop_front();
                    if (act_v !== exp_v) begin
                        miscompares = miscompares + 1;
                        $display("FAIL dut1 cycle %0d: got rdy/rst/busy/chg/on/err/cnt %h, want %h", cyc, act_v, exp_v);
                    end
                end
            end
        end
    end

    initial begin
        m_cnt  = '{0, 0};
        m_ptr  = '{0, 0};
        m_left = '{0, 0};
        m_out  = '{13'd0, 13'd0};
        #1 rst_n = 1'b0;
        repeat (4)    drive_cycle(50, 100, 0, 0);
        // Mostly connects: saturates the no-wrap instance and wraps the other.
        repeat (700)  drive_cycle(90, 100, 0, 0);
        // Mostly disconnects: drains to zero and exercises underflow drops.
        repeat (400)  drive_cycle(90, 0, 0, 0);
        // Mixed traffic with clears and occasional asynchronous resets.
        repeat (2000) drive_cycle(40, 50, 3, 5);
        #2;
        done = 1'b1;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL leftover: got %0d/%0d unchecked entries, want 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
